adpll_lock_seq: RTL and testbench

//  Power-up and lock sequencer for the ADPLL. It powers up the DCO and TDC,

---
 rtl/adpll_lock_seq.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_adpll_lock_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpll_lock_seq.sv
// ---------------------------------------------------------------------------
// adpll_lock_seq
//
// Power-up and lock sequencer for the ADPLL. It releases the DCO/TDC power
// downs, steps the loop filter through the PVT -> ACQ -> TRK tuning modes and
// qualifies each step with a phase-error quality check. channel_lock is
// asserted once tracking has settled. A mode that does not settle within
// MAX_CYC cycles parks the sequencer in FAIL with a sticky timeout_err.
//
// Optional feature (compile-time macro ADPLL_RELOCK_EN):
//   defined   - in LOCK, 4 consecutive valid samples with |phase_err| above
//               UNLOCK_TH drop channel_lock and restart from ACQ.
//   undefined - LOCK is sticky and phase_err is ignored there.
//
// Ports
//   clk          in   1     loop reference clock
//   rst          in   1     synchronous reset, active-high
//   en           in   1     ADPLL enable; low aborts to IDLE
//   phase_err    in   PE_W  signed phase error from the loop datapath
//   phase_valid  in   1     phase_err qualifier
//   dco_pd       out  1     DCO power-down
//   tdc_pd       out  1     TDC power-down
//   tdc_pd_inj   out  1     TDC injection power-down
//   mode         out  2     0=PVT 1=ACQ 2=TRK (DCO bank / filter gains)
//   filt_rst     out  1     loop-filter / bank-accumulator clear
//   channel_lock out  1     loop locked
//   timeout_err  out  1     sticky, set on mode timeout
//   state        out  3     FSM state, for debug
// ---------------------------------------------------------------------------
module adpll_lock_seq #(
    parameter int PE_W       = 12,
    parameter int PWR_WAIT   = 16,
    parameter int SETTLE_CNT = 8,
    parameter int LOCK_CNT   = 32,
    parameter int MAX_CYC    = 1024,
    parameter int TH_PVT     = 256,
    parameter int TH_ACQ     = 32,
    parameter int TH_TRK     = 4,
    parameter int UNLOCK_TH  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic signed [PE_W-1:0] phase_err,
    input  logic                   phase_valid,
    output logic                   dco_pd,
    output logic                   tdc_pd,
    output logic                   tdc_pd_inj,
    output logic [1:0]             mode,
    output logic                   filt_rst,
    output logic                   channel_lock,
    output logic                   timeout_err,
    output logic [2:0]             state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PWRUP = 3'd1;
    localparam logic [2:0] S_PVT   = 3'd2;
    localparam logic [2:0] S_ACQ   = 3'd3;
    localparam logic [2:0] S_TRK   = 3'd4;
    localparam logic [2:0] S_LOCK  = 3'd5;
    localparam logic [2:0] S_FAIL  = 3'd6;

    // One cycle counter serves both the power-up wait and the mode timeout.
    localparam int CYC_MAX  = (MAX_CYC > PWR_WAIT) ? MAX_CYC : PWR_WAIT;
    localparam int CYC_W    = $clog2(CYC_MAX + 1);
    localparam int GOOD_MAX = (LOCK_CNT > SETTLE_CNT) ? LOCK_CNT : SETTLE_CNT;
    localparam int GOOD_W   = $clog2(GOOD_MAX + 1);
    localparam int ABS_W    = PE_W - 1;

    localparam logic [CYC_W-1:0]  PWR_WAIT_C = CYC_W'(PWR_WAIT);
    localparam logic [CYC_W-1:0]  MAX_CYC_C  = CYC_W'(MAX_CYC);
    localparam logic [GOOD_W-1:0] SETTLE_C   = GOOD_W'(SETTLE_CNT);
    localparam logic [GOOD_W-1:0] LOCK_C     = GOOD_W'(LOCK_CNT);
    localparam logic [ABS_W-1:0]  TH_PVT_C   = ABS_W'(TH_PVT);
    localparam logic [ABS_W-1:0]  TH_ACQ_C   = ABS_W'(TH_ACQ);
    localparam logic [ABS_W-1:0]  TH_TRK_C   = ABS_W'(TH_TRK);
    localparam logic [ABS_W-1:0]  UNLOCK_C   = ABS_W'(UNLOCK_TH);
    localparam logic [2:0]        RUN_C      = 3'd4;

`ifdef ADPLL_RELOCK_EN
    localparam bit RELOCK_EN = 1'b1;
`else
    localparam bit RELOCK_EN = 1'b0;
`endif

    logic [2:0]        state_q, state_d;
    logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [2:0]        bad_run_q, bad_run_d;
    logic              dco_pd_q, dco_pd_d;
    logic              tdc_pd_q, tdc_pd_d;
    logic              tdc_pd_inj_q, tdc_pd_inj_d;
    logic [1:0]        mode_q, mode_d;
    logic              filt_rst_q, filt_rst_d;
    logic              channel_lock_q, channel_lock_d;
    logic              timeout_err_q, timeout_err_d;

    logic [ABS_W-1:0]  abs_err;
    logic [ABS_W-1:0]  th_sel;
    logic [GOOD_W-1:0] good_tgt;
    logic [2:0]        mode_next;
    logic [GOOD_W-1:0] good_nxt;
    logic [CYC_W-1:0]  cyc_inc;

    // |phase_err| on PE_W-1 bits: the two's complement of the low bits gives
    // the magnitude of any negative value except the most negative one,
    // whose low bits are all zero and which saturates to the largest code.
    always_comb begin
        if (!phase_err[PE_W-1]) begin
            abs_err = phase_err[ABS_W-1:0];
        end else if (phase_err[ABS_W-1:0] == '0) begin
            abs_err = '1;
        end else begin
            abs_err = ~phase_err[ABS_W-1:0] + ABS_W'(1);
        end
    end

    // Per-mode quality threshold, settle target and successor state.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        th_sel    = TH_PVT_C;
        good_tgt  = SETTLE_C;
        mode_next = S_ACQ;
        case (state_q)
            S_ACQ: begin
                th_sel    = TH_ACQ_C;
                mode_next = S_TRK;
            end
            S_TRK: begin
                th_sel    = TH_TRK_C;
                good_tgt  = LOCK_C;
                mode_next = S_LOCK;
            end
            default: ;
        endcase
    end

    // Good-sample count including this cycle's sample; invalid cycles hold.
    always_comb begin
        if (!phase_valid) begin
            good_nxt = good_cnt_q;
        end else if (abs_err <= th_sel) begin
            good_nxt = good_cnt_q + GOOD_W'(1);
        end else begin
            good_nxt = '0;
        end
    end

    assign cyc_inc = cyc_cnt_q + CYC_W'(1);

    // Next state and counters.
    always_comb begin
        state_d       = state_q;
        cyc_cnt_d     = cyc_cnt_q;
        good_cnt_d    = good_cnt_q;
        bad_run_d     = bad_run_q;
        timeout_err_d = timeout_err_q;

        if (!en) begin
            // timeout_err is intentionally retained across an abort.
            state_d    = S_IDLE;
            cyc_cnt_d  = '0;
            good_cnt_d = '0;
            bad_run_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d       = S_PWRUP;
                    timeout_err_d = 1'b0;
                    cyc_cnt_d     = '0;
                end
                S_PWRUP: begin
                    if (cyc_inc == PWR_WAIT_C) begin
                        state_d    = S_PVT;
                        cyc_cnt_d  = '0;
                        good_cnt_d = '0;
                    end else begin
                        cyc_cnt_d = cyc_inc;
                    end
                end
                S_PVT, S_ACQ, S_TRK: begin
                    // Settle is tested first so it wins over a coincident
                    // timeout.
                    if (good_nxt == good_tgt) begin
                        state_d    = mode_next;
                        cyc_cnt_d  = '0;
                        good_cnt_d = '0;
                        bad_run_d  = '0;
                    end else if (cyc_inc == MAX_CYC_C) begin
                        state_d       = S_FAIL;
                        timeout_err_d = 1'b1;
                        cyc_cnt_d     = '0;
                        good_cnt_d    = '0;
                    end else begin
                        cyc_cnt_d  = cyc_inc;
                        good_cnt_d = good_nxt;
                    end
                end
                S_LOCK: begin
                    if (RELOCK_EN && phase_valid) begin
                        if (abs_err > UNLOCK_C) begin
                            if (bad_run_q + 3'd1 == RUN_C) begin
                                state_d    = S_ACQ;
                                cyc_cnt_d  = '0;
                                good_cnt_d = '0;
                                bad_run_d  = '0;
                            end else begin
                                bad_run_d = bad_run_q + 3'd1;
                            end
                        end else begin
                            bad_run_d = '0;
                        end
                    end
                end
                S_FAIL: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Registered outputs are decoded from the state being entered, so they
    // line up with the debug state output.
    always_comb begin
        dco_pd_d       = 1'b1;
        tdc_pd_d       = 1'b1;
        tdc_pd_inj_d   = 1'b1;
        mode_d         = 2'd0;
        filt_rst_d     = 1'b1;
        channel_lock_d = 1'b0;
        case (state_d)
            S_PWRUP: begin
                dco_pd_d = 1'b0;
                tdc_pd_d = 1'b0;
            end
            S_PVT, S_ACQ, S_TRK: begin
                dco_pd_d     = 1'b0;
                tdc_pd_d     = 1'b0;
                tdc_pd_inj_d = (state_d != S_TRK);
                mode_d       = (state_d == S_PVT) ? 2'd0 :
                               (state_d == S_ACQ) ? 2'd1 : 2'd2;
                // Filter clear only on the first cycle of a tuning mode.
                filt_rst_d   = (state_q != state_d);
            end
            S_LOCK: begin
                dco_pd_d       = 1'b0;
                tdc_pd_d       = 1'b0;
                tdc_pd_inj_d   = 1'b0;
                mode_d         = 2'd2;
                filt_rst_d     = 1'b0;
                channel_lock_d = 1'b1;
            end
            default: ; // IDLE and FAIL keep the power-down defaults
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q        <= S_IDLE;
            cyc_cnt_q      <= '0;
            good_cnt_q     <= '0;
            bad_run_q      <= '0;
            dco_pd_q       <= 1'b1;
            tdc_pd_q       <= 1'b1;
            tdc_pd_inj_q   <= 1'b1;
            mode_q         <= 2'd0;
            filt_rst_q     <= 1'b1;
            channel_lock_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cyc_cnt_q      <= cyc_cnt_d;
            good_cnt_q     <= good_cnt_d;
            bad_run_q      <= bad_run_d;
            dco_pd_q       <= dco_pd_d;
            tdc_pd_q       <= tdc_pd_d;
            tdc_pd_inj_q   <= tdc_pd_inj_d;
            mode_q         <= mode_d;
            filt_rst_q     <= filt_rst_d;
            channel_lock_q <= channel_lock_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign state        = state_q;
    assign dco_pd       = dco_pd_q;
    assign tdc_pd       = tdc_pd_q;
    assign tdc_pd_inj   = tdc_pd_inj_q;
    assign mode         = mode_q;
    assign filt_rst     = filt_rst_q;
    assign channel_lock = channel_lock_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_adpll_lock_seq.sv
// ---------------------------------------------------------------------------
// tb_adpll_lock_seq
//
// Self-checking bench for adpll_lock_seq (default parameters). Every clock is
// compared against a cycle model built from the sequencer's rules; directed
// sequences add fixed-cycle milestone checks, and a table exercises the
// |phase_err| boundary and valid-gap behaviour in PVT. Honors
// ADPLL_RELOCK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_adpll_lock_seq;

    localparam int PE_W       = 12;
    localparam int PWR_WAIT   = 16;
    localparam int SETTLE_CNT = 8;
    localparam int LOCK_CNT   = 32;
    localparam int MAX_CYC    = 1024;
    localparam int TH_PVT     = 256;
    localparam int TH_ACQ     = 32;
    localparam int TH_TRK     = 4;
    localparam int UNLOCK_TH  = 64;

    localparam int IDLE = 0, PWRUP = 1, PVT = 2, ACQ = 3, TRK = 4, LOCK = 5, FAIL = 6;

`ifdef ADPLL_RELOCK_EN
    localparam bit RELOCK = 1'b1;
`else
    localparam bit RELOCK = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic signed [PE_W-1:0] phase_err;
    logic                   phase_valid;
    logic                   dco_pd, tdc_pd, tdc_pd_inj, filt_rst, channel_lock, timeout_err;
    logic [1:0]             mode;
    logic [2:0]             state;

    adpll_lock_seq dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .phase_err    (phase_err),
        .phase_valid  (phase_valid),
        .dco_pd       (dco_pd),
        .tdc_pd       (tdc_pd),
        .tdc_pd_inj   (tdc_pd_inj),
        .mode         (mode),
        .filt_rst     (filt_rst),
        .channel_lock (channel_lock),
        .timeout_err  (timeout_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    int m_st, m_cyc, m_good, m_bad;
    bit m_terr, m_fresh;

    function automatic int abs_sat(input int e);
        int a;
        a = (e < 0) ? -e : e;
        return (a > 2047) ? 2047 : a;
    endfunction

    task automatic m_enter(input int st);
        m_st    = st;
        m_cyc   = 0;
        m_good  = 0;
        m_bad   = 0;
        m_fresh = 1'b1;
    endtask

    task automatic model_step();
        int a, th, tgt, nxt;
        a       = abs_sat(int'(phase_err));
        m_fresh = 1'b0;
        if (rst) begin
            m_st = IDLE; m_cyc = 0; m_good = 0; m_bad = 0; m_terr = 1'b0;
        end else if (!en) begin
            m_st = IDLE; m_cyc = 0; m_good = 0; m_bad = 0;
        end else begin
            case (m_st)
                IDLE: begin
                    m_st = PWRUP; m_cyc = 0; m_terr = 1'b0;
                end
                PWRUP: begin
                    m_cyc++;
                    if (m_cyc == PWR_WAIT) m_enter(PVT);
                end
                PVT, ACQ, TRK: begin
                    th  = (m_st == PVT) ? TH_PVT : (m_st == ACQ) ? TH_ACQ : TH_TRK;
                    tgt = (m_st == TRK) ? LOCK_CNT : SETTLE_CNT;
                    nxt = (m_st == PVT) ? ACQ : (m_st == ACQ) ? TRK : LOCK;
                    m_cyc++;
                    if (phase_valid) m_good = (a <= th) ? m_good + 1 : 0;
                    if (m_good == tgt) m_enter(nxt);
                    else if (m_cyc == MAX_CYC) begin
                        m_st = FAIL; m_terr = 1'b1;
                    end
                end
                LOCK: begin
                    if (RELOCK && phase_valid) begin
                        m_bad = (a > UNLOCK_TH) ? m_bad + 1 : 0;
                        if (m_bad == 4) m_enter(ACQ);
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] pack(input int st, input bit dco, input bit tdc,
                                         input bit inj, input int md, input bit filt,
                                         input bit lck, input bit terr);
        logic [2:0] s3;
        logic [1:0] m2;
        s3 = st[2:0];
        m2 = md[1:0];
        return {21'd0, s3, dco, tdc, inj, m2, filt, lck, terr};
    endfunction

    function automatic logic [31:0] model_bus();
        bit off, tune, fl;
        int md;
        off  = (m_st == IDLE) || (m_st == FAIL);
        tune = (m_st == PVT) || (m_st == ACQ) || (m_st == TRK);
        md   = (m_st == ACQ) ? 1 : (m_st == TRK || m_st == LOCK) ? 2 : 0;
        fl   = off || (m_st == PWRUP) || (tune && m_fresh);
        return pack(m_st, off, off, !(m_st == TRK || m_st == LOCK), md, fl,
                    m_st == LOCK, m_terr);
    endfunction

    function automatic logic [31:0] dut_bus();
        return {21'd0, state, dco_pd, tdc_pd, tdc_pd_inj, mode, filt_rst,
                channel_lock, timeout_err};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit e, input int err, input bit v);
        en          = e;
        phase_err   = err[PE_W-1:0];
        phase_valid = v;
    endtask

    // One clock: model follows the sampled inputs, outputs compared 1 ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag, dut_bus(), model_bus());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0);
        tick("reset");
        check("reset_values", dut_bus(), pack(IDLE, 1, 1, 1, 0, 1, 0, 0));
        rst = 1'b0;
    endtask

    typedef struct {
        bit         valid;
        int         err;
        logic [2:0] st;
        logic [1:0] md;
        bit         filt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // PVT boundary / gap table; row 0 is the first PVT sample.
        tbl[0]  = '{1'b1, -2048, 3'd2, 2'd0, 1'b0};  // saturates to 2047: bad
        tbl[1]  = '{1'b1, -256,  3'd2, 2'd0, 1'b0};  // boundary: good (1)
        tbl[2]  = '{1'b1, -256,  3'd2, 2'd0, 1'b0};  // 2
        tbl[3]  = '{1'b0, 0,     3'd2, 2'd0, 1'b0};  // gap holds 2
        tbl[4]  = '{1'b0, 2047,  3'd2, 2'd0, 1'b0};  // invalid large ignored
        tbl[5]  = '{1'b1, 256,   3'd2, 2'd0, 1'b0};  // 3
        tbl[6]  = '{1'b1, 257,   3'd2, 2'd0, 1'b0};  // above threshold: 0
        for (int i = 7; i < 14; i++) tbl[i] = '{1'b1, -256, 3'd2, 2'd0, 1'b0};
        tbl[14] = '{1'b1, -256,  3'd3, 2'd1, 1'b1};  // 8th good -> ACQ entry

        rst = 1'b1;
        drive(0, 0, 0);

        // ---- 1: clean lock sequence with fixed cycle milestones ----
        do_reset();
        drive(1, 0, 1);
        for (int k = 0; k <= 64; k++) begin
            tick("t1");
            case (k)
                15: check("t1_pwrup_last", {29'd0, state}, PWRUP);
                16: check("t1_pvt_first", dut_bus(), pack(PVT, 0, 0, 1, 0, 1, 0, 0));
                17: check("t1_pvt_filt_drop", {31'd0, filt_rst}, 0);
                23: check("t1_pvt_last", {29'd0, state}, PVT);
                24: check("t1_acq_first", dut_bus(), pack(ACQ, 0, 0, 1, 1, 1, 0, 0));
                32: check("t1_trk_first", dut_bus(), pack(TRK, 0, 0, 0, 2, 1, 0, 0));
                63: check("t1_trk_last_nolock", {31'd0, channel_lock}, 0);
                64: check("t1_lock", dut_bus(), pack(LOCK, 0, 0, 0, 2, 0, 1, 0));
                default: ;
            endcase
        end

        // ---- 6: behaviour in LOCK under large phase error ----
        begin
            int seq[8] = '{100, 100, 100, 0, 100, 100, 100, 100};
            for (int i = 0; i < 8; i++) begin
                drive(1, seq[i], 1);
                tick("t6");
                if (i == 6) check("t6_three_bad_hold", {31'd0, channel_lock}, 1);
            end
            check("t6_lock_after_four", {31'd0, channel_lock}, {31'd0, !RELOCK});
            check("t6_mode_after_four", {30'd0, mode}, RELOCK ? 1 : 2);
        end

        // ---- 5: PVT boundary table ----
        do_reset();
        drive(1, 0, 1);
        for (int k = 0; k <= 16; k++) tick("t5_pre");
        for (int i = 0; i < 15; i++) begin
            drive(1, tbl[i].err, tbl[i].valid);
            tick("t5_row");
            check($sformatf("t5_row%0d", i), {27'd0, state, mode},
                  {27'd0, tbl[i].st, tbl[i].md});
            check($sformatf("t5_row%0d_filt", i), {31'd0, filt_rst}, {31'd0, tbl[i].filt});
        end

        // ---- 2: PVT timeout, abort keeps timeout_err, restart clears it ----
        do_reset();
        drive(1, 300, 1);
        for (int k = 0; k <= 1040; k++) begin
            tick("t2");
            if (k == 1039) check("t2_pvt_last", {29'd0, state}, PVT);
        end
        check("t2_fail", dut_bus(), pack(FAIL, 1, 1, 1, 0, 1, 0, 1));
        drive(0, 300, 1);
        tick("t2_abort");
        check("t2_idle_keeps_terr", dut_bus(), pack(IDLE, 1, 1, 1, 0, 1, 0, 1));
        drive(1, 300, 1);
        tick("t2_restart");
        check("t2_pwrup_clears_terr", dut_bus(), pack(PWRUP, 0, 0, 1, 0, 1, 0, 0));

        // ---- 3: TRK never settles with alternating 3/5 ----
        do_reset();
        drive(1, 0, 1);
        for (int k = 0; k <= 1056; k++) begin
            if (k >= 33) drive(1, (k % 2) ? 3 : 5, 1);
            tick("t3");
            if (k == 1055) check("t3_trk_last", {29'd0, state}, TRK);
        end
        check("t3_fail", dut_bus(), pack(FAIL, 1, 1, 1, 0, 1, 0, 1));

        // ---- 4: en drop mid-ACQ, rst mid-TRK ----
        do_reset();
        drive(1, 0, 1);
        for (int k = 0; k <= 27; k++) tick("t4a");
        drive(0, 0, 1);
        tick("t4_en_low");
        check("t4_en_low_idle", dut_bus(), pack(IDLE, 1, 1, 1, 0, 1, 0, 0));
        drive(1, 0, 1);
        for (int k = 0; k <= 40; k++) tick("t4b");
        check("t4_in_trk", {29'd0, state}, TRK);
        rst = 1'b1;
        tick("t4_rst");
        check("t4_rst_idle", dut_bus(), pack(IDLE, 1, 1, 1, 0, 1, 0, 0));
        rst = 1'b0;

        // ---- randomized run against the model ----
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            int noise;
            noise = (seg % 2) ? 4 : 64;
            for (int c = 0; c < 600; c++) begin
                int pick, e;
                pick = $urandom_range(0, noise - 1);
                if (pick == 0)      e = $urandom_range(0, 4095) - 2048;
                else if (pick == 1) e = $urandom_range(0, 80) - 40;
                else                e = $urandom_range(0, 8) - 4;
                rst = ($urandom_range(0, 999) == 0);
                drive($urandom_range(0, 599) != 0, e, $urandom_range(0, 9) != 0);
                tick("rand");
            end
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
